sbp_lookup_sched: RTL and testbench
===================================

# sbp_lookup_sched

Request scheduler in front of the `sbp_lookup` pipeline. It takes one lookup stream and one table-update stream (valid/ready) and maps them onto the pipeline's two ports. Port 0 is shared by updates and lookups, and updates take port 0 when present. Port 1 carries lookups only, so a lookup is never blocked by an update. The block tags each lookup, tracks it through the fixed pipeline latency and returns one in-order result stream. An update barrier lets software stall lookups until an update has fully drained.

## Interface
- `PIPE_LATENCY`, 65: cycles from `sbp_lookup` input presentation to its matching `result_o`/`result2_o`; must equal the instantiated pipeline's latency.
- `TAG_BITS`, 8: lookup tag width.
- `STAGE_ID_BITS`, 6: stage id width.
- `LOCATION_BITS`, 11: location width.
- `RESULT_BITS`, 24: width of the padded result word.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `lkp_valid_i` in 1: lookup request.
- `lkp_ready_o` out 1: lookup accepted when high with valid.
- `lkp_ip_addr_i` in 32: address to look up.
- `lkp_tag_i` in TAG_BITS: opaque tag, returned with the result.
- `upd_valid_i` in 1: update request.
- `upd_ready_o` out 1: update accept.
- `upd_barrier_i` in 1: this update is a barrier.
- `upd_prefix_i` in 32: prefix to write.
- `upd_length_i` in 6: prefix length.
- `upd_stage_id_i` in STAGE_ID_BITS: target stage.
- `upd_location_i` in LOCATION_BITS: target location.
- `upd_childs_stage_id_i` in STAGE_ID_BITS: child pointer stage id.
- `upd_childs_location_i` in LOCATION_BITS: child pointer location.
- `upd_childs_lr_i` in 2: child left/right flags.
- `sbp_upd_o`, `sbp_upd_stage_id_o`, `sbp_upd_location_o`, `sbp_upd_length_o`, `sbp_upd_childs_stage_id_o`, `sbp_upd_childs_location_o`, `sbp_upd_childs_lr_o` out (matching widths): registered drive to the pipeline update port.
- `sbp_ip_addr_o` out 32: pipeline port 0 address/prefix.
- `sbp_ip_addr2_o` out 32: pipeline port 1 address.
- `sbp_result_i` in RESULT_BITS: pipeline port 0 result.
- `sbp_result2_i` in RESULT_BITS: pipeline port 1 result.
- `res_valid_o` out 1: result strobe, no backpressure.
- `res_tag_o` out TAG_BITS: tag of the returned lookup.
- `res_ip_addr_o` out 32: looked-up address.
- `res_result_o` out RESULT_BITS: lookup result.
- `upd_busy_o` out 1: at least one update is in flight in the pipeline.

## Operation
- FSM states: RUN and DRAIN.
- In RUN:
  - `lkp_ready_o` = 1 and `upd_ready_o` = 1.
  - An accepted update drives port 0: `sbp_upd_o` = 1 and `sbp_ip_addr_o` = prefix.
  - An accepted lookup uses port 0 if no update is accepted that cycle, otherwise port 1.
  - An update and a lookup accepted in the same cycle are both issued.
- Idle port 0: `sbp_upd_o` = 0 and address 0. An idle port 1 drives address 0. These dummy lookups are never reported.
- Barrier (accepted update with `upd_barrier_i` = 1):
  - The update is issued, then the FSM enters DRAIN with a counter loaded to PIPE_LATENCY.
  - In DRAIN, `lkp_ready_o` = 0 and `upd_ready_o` = 0. The counter decrements every cycle; at 0 the FSM returns to RUN.
  - The first post-barrier lookup is therefore issued at least PIPE_LATENCY cycles after the barrier update.
- Tracking: a PIPE_LATENCY-deep shift register carries {valid, port, tag, ip_addr} per issued cycle. At the tap, the result is taken from `sbp_result_i` or `sbp_result2_i` according to the port bit.
- At most one lookup is issued per cycle, so at most one result is returned per cycle, in acceptance order.
- `upd_busy_o`: an in-flight update counter, incremented on issue and decremented PIPE_LATENCY cycles later. It is sized $clog2(PIPE_LATENCY+1). An increment and a decrement in the same cycle leave it unchanged.
- Update field packing into the pipeline is a pass-through; padding is done downstream.

## Timing
- Request accepted at edge t:
  - `sbp_*` outputs are valid in cycle t+1.
  - The pipeline result appears in cycle t+1+PIPE_LATENCY.
  - `res_*_o` is registered and valid in cycle t+2+PIPE_LATENCY.
- The barrier update is accepted at t. The FSM is in DRAIN during cycles t+1 through t+1+PIPE_LATENCY, and ready rises in cycle t+2+PIPE_LATENCY.
- Reset values:
  - All outputs 0 except the ready outputs.
  - `lkp_ready_o` = 0 and `upd_ready_o` = 0 while `rst` = 1. Both are 1 in the first cycle after reset.
  - FSM in RUN, counters 0, all tracking valid bits 0.
- Reset mid-operation: all in-flight lookups are discarded with no `res_valid_o` for them, `upd_busy_o` goes to 0, and DRAIN is aborted. Table writes already issued to the pipeline still complete.
- A barrier accepted while `upd_busy_o` = 1 still waits the full PIPE_LATENCY from its own issue.

## Test plan
- Single lookup: address 0x0A000001, tag 0x11 at t. `sbp_ip_addr_o` = 0x0A000001 at t+1, and `res_valid_o` fires with tag 0x11 at t+2+PIPE_LATENCY with `res_result_o` = the model's `sbp_result_i`.
- Simultaneous lookup and update: update goes on port 0 with `sbp_upd_o` = 1; the lookup goes on `sbp_ip_addr2_o`. The result is taken from `sbp_result2_i`, with no stall on either stream.
- 100 back-to-back lookups interleaved with random updates: 100 results in order, tags 0..99, no gaps and no duplicates.
- Barrier update followed by a pending lookup: `lkp_ready_o` is low for exactly PIPE_LATENCY+1 cycles. The lookup issues only after that and observes the updated model table.
- `upd_busy_o`: 3 updates at t, t+1, t+5. `upd_busy_o` is high from t+1 through t+5+PIPE_LATENCY, then low.
- Reset asserted for one cycle with 10 lookups in flight: no `res_valid_o` for them, ready outputs return to 1 the next cycle, and a new lookup returns with the correct latency.

Source files
------------

// File: rtl/sbp_lookup_sched.sv
// Request scheduler in front of the sbp_lookup pipeline: maps one lookup stream and one update
// stream onto the two pipeline ports and returns tagged lookup results in acceptance order.
`timescale 1ns/1ps
module sbp_lookup_sched #(
  parameter int unsigned PIPE_LATENCY  = 65,
  parameter int unsigned TAG_BITS      = 8,
  parameter int unsigned STAGE_ID_BITS = 6,
  parameter int unsigned LOCATION_BITS = 11,
  parameter int unsigned RESULT_BITS   = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lkp_valid_i,
  output logic                     lkp_ready_o,
  input  logic [31:0]              lkp_ip_addr_i,
  input  logic [TAG_BITS-1:0]      lkp_tag_i,
  input  logic                     upd_valid_i,
  output logic                     upd_ready_o,
  input  logic                     upd_barrier_i,
  input  logic [31:0]              upd_prefix_i,
  input  logic [5:0]               upd_length_i,
  input  logic [STAGE_ID_BITS-1:0] upd_stage_id_i,
  input  logic [LOCATION_BITS-1:0] upd_location_i,
  input  logic [STAGE_ID_BITS-1:0] upd_childs_stage_id_i,
  input  logic [LOCATION_BITS-1:0] upd_childs_location_i,
  input  logic [1:0]               upd_childs_lr_i,
  output logic                     sbp_upd_o,
  output logic [STAGE_ID_BITS-1:0] sbp_upd_stage_id_o,
  output logic [LOCATION_BITS-1:0] sbp_upd_location_o,
  output logic [5:0]               sbp_upd_length_o,
  output logic [STAGE_ID_BITS-1:0] sbp_upd_childs_stage_id_o,
  output logic [LOCATION_BITS-1:0] sbp_upd_childs_location_o,
  output logic [1:0]               sbp_upd_childs_lr_o,
  output logic [31:0]              sbp_ip_addr_o,
  output logic [31:0]              sbp_ip_addr2_o,
  input  logic [RESULT_BITS-1:0]   sbp_result_i,
  input  logic [RESULT_BITS-1:0]   sbp_result2_i,
  output logic                     res_valid_o,
  output logic [TAG_BITS-1:0]      res_tag_o,
  output logic [31:0]              res_ip_addr_o,
  output logic [RESULT_BITS-1:0]   res_result_o,
  output logic                     upd_busy_o
);

  localparam int unsigned CntW = $clog2(PIPE_LATENCY + 1);

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  typedef struct packed {
    logic                vld;
    logic                port;
    logic [TAG_BITS-1:0] tag;
    logic [31:0]         addr;
  } trk_t;

  state_e          state_q, state_d;
  logic [CntW-1:0] drain_cnt_q, drain_cnt_d;
  logic [CntW-1:0] busy_q, busy_d;
  logic            lkp_acc, upd_acc, upd_retire;

  logic                     sbp_upd_q;
  logic [STAGE_ID_BITS-1:0] sbp_stage_id_q, sbp_childs_stage_id_q;
  logic [LOCATION_BITS-1:0] sbp_location_q, sbp_childs_location_q;
  logic [5:0]               sbp_length_q;
  logic [1:0]               sbp_childs_lr_q;
  logic [31:0]              sbp_addr_q, sbp_addr_d, sbp_addr2_q, sbp_addr2_d;

  trk_t                     iss_q, iss_d, tap;
  trk_t                     trk_q [PIPE_LATENCY];
  logic [PIPE_LATENCY-1:0]  upd_line_q;

  logic                     res_valid_q;
  logic [TAG_BITS-1:0]      res_tag_q;
  logic [31:0]              res_addr_q;
  logic [RESULT_BITS-1:0]   res_result_q;

  assign lkp_ready_o = ~rst & (state_q == StRun);
  assign upd_ready_o = ~rst & (state_q == StRun);
  assign lkp_acc     = lkp_valid_i & lkp_ready_o;
  assign upd_acc     = upd_valid_i & upd_ready_o;
  assign upd_retire  = upd_line_q[PIPE_LATENCY-1];
  assign tap         = trk_q[PIPE_LATENCY-1];

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      StRun: begin
        if (upd_acc && upd_barrier_i) begin
          state_d     = StDrain;
          drain_cnt_d = CntW'(PIPE_LATENCY);
        end
      end
      StDrain: begin
        if (drain_cnt_q == '0) state_d = StRun;
        else                   drain_cnt_d = drain_cnt_q - 1'b1;
      end
      default: state_d = StRun;
    endcase
  end

  // Updates own port 0; a lookup accepted alongside an update moves to port 1.
  always_comb begin
    sbp_addr_d  = '0;
    sbp_addr2_d = '0;
    iss_d       = '0;
    iss_d.vld   = lkp_acc;
    iss_d.port  = upd_acc;
    iss_d.tag   = lkp_tag_i;
    iss_d.addr  = lkp_ip_addr_i;
    if (upd_acc) begin
      sbp_addr_d = upd_prefix_i;
      if (lkp_acc) sbp_addr2_d = lkp_ip_addr_i;
    end else if (lkp_acc) begin
      sbp_addr_d = lkp_ip_addr_i;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (upd_acc && !upd_retire)      busy_d = busy_q + CntW'(1);
    else if (!upd_acc && upd_retire) busy_d = busy_q - CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q               <= StRun;
      drain_cnt_q           <= '0;
      busy_q                <= '0;
      upd_line_q            <= '0;
      sbp_upd_q             <= 1'b0;
      sbp_stage_id_q        <= '0;
      sbp_location_q        <= '0;
      sbp_length_q          <= '0;
      sbp_childs_stage_id_q <= '0;
      sbp_childs_location_q <= '0;
      sbp_childs_lr_q       <= '0;
      sbp_addr_q            <= '0;
      sbp_addr2_q           <= '0;
      iss_q                 <= '0;
    end else begin
      state_q               <= state_d;
      drain_cnt_q           <= drain_cnt_d;
      busy_q                <= busy_d;
      upd_line_q            <= {upd_line_q[PIPE_LATENCY-2:0], upd_acc};
      sbp_upd_q             <= upd_acc;
      sbp_stage_id_q        <= upd_acc ? upd_stage_id_i : '0;
      sbp_location_q        <= upd_acc ? upd_location_i : '0;
      sbp_length_q          <= upd_acc ? upd_length_i : '0;
      sbp_childs_stage_id_q <= upd_acc ? upd_childs_stage_id_i : '0;
      sbp_childs_location_q <= upd_acc ? upd_childs_location_i : '0;
      sbp_childs_lr_q       <= upd_acc ? upd_childs_lr_i : '0;
      sbp_addr_q            <= sbp_addr_d;
      sbp_addr2_q           <= sbp_addr2_d;
      iss_q                 <= iss_d;
    end
  end

  // Tracker runs one stage behind the issue registers so its tap lines up with the pipeline result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(PIPE_LATENCY); i++) trk_q[i] <= '0;
    end else begin
      trk_q[0] <= iss_q;
      for (int i = 1; i < int'(PIPE_LATENCY); i++) trk_q[i] <= trk_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q  <= 1'b0;
      res_tag_q    <= '0;
      res_addr_q   <= '0;
      res_result_q <= '0;
    end else begin
      res_valid_q <= tap.vld;
      if (tap.vld) begin
        res_tag_q    <= tap.tag;
        res_addr_q   <= tap.addr;
        res_result_q <= tap.port ? sbp_result2_i : sbp_result_i;
      end
    end
  end

  assign sbp_upd_o                 = sbp_upd_q;
  assign sbp_upd_stage_id_o        = sbp_stage_id_q;
  assign sbp_upd_location_o        = sbp_location_q;
  assign sbp_upd_length_o          = sbp_length_q;
  assign sbp_upd_childs_stage_id_o = sbp_childs_stage_id_q;
  assign sbp_upd_childs_location_o = sbp_childs_location_q;
  assign sbp_upd_childs_lr_o       = sbp_childs_lr_q;
  assign sbp_ip_addr_o             = sbp_addr_q;
  assign sbp_ip_addr2_o            = sbp_addr2_q;
  assign res_valid_o               = res_valid_q;
  assign res_tag_o                 = res_tag_q;
  assign res_ip_addr_o             = res_addr_q;
  assign res_result_o              = res_result_q;
  assign upd_busy_o                = (busy_q != '0);

endmodule

// File: tb/tb_sbp_lookup_sched.sv
// Bench for sbp_lookup_sched: behavioural two-port pipeline model plus an in-order result scoreboard.
`timescale 1ns/1ps
module tb_sbp_lookup_sched;

  localparam int L = 65;

  logic        clk, rst;
  logic        lkp_valid_i, lkp_ready_o, upd_valid_i, upd_ready_o, upd_barrier_i;
  logic [31:0] lkp_ip_addr_i, upd_prefix_i;
  logic [7:0]  lkp_tag_i;
  logic [5:0]  upd_length_i, upd_stage_id_i, upd_childs_stage_id_i;
  logic [10:0] upd_location_i, upd_childs_location_i;
  logic [1:0]  upd_childs_lr_i;
  logic        sbp_upd_o;
  logic [5:0]  sbp_upd_stage_id_o, sbp_upd_length_o, sbp_upd_childs_stage_id_o;
  logic [10:0] sbp_upd_location_o, sbp_upd_childs_location_o;
  logic [1:0]  sbp_upd_childs_lr_o;
  logic [31:0] sbp_ip_addr_o, sbp_ip_addr2_o, res_ip_addr_o;
  logic [23:0] sbp_result_i, sbp_result2_i, res_result_o;
  logic        res_valid_o, upd_busy_o;
  logic [7:0]  res_tag_o;

  sbp_lookup_sched #(.PIPE_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .lkp_valid_i(lkp_valid_i), .lkp_ready_o(lkp_ready_o), .lkp_ip_addr_i(lkp_ip_addr_i),
    .lkp_tag_i(lkp_tag_i),
    .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o), .upd_barrier_i(upd_barrier_i),
    .upd_prefix_i(upd_prefix_i), .upd_length_i(upd_length_i), .upd_stage_id_i(upd_stage_id_i),
    .upd_location_i(upd_location_i), .upd_childs_stage_id_i(upd_childs_stage_id_i),
    .upd_childs_location_i(upd_childs_location_i), .upd_childs_lr_i(upd_childs_lr_i),
    .sbp_upd_o(sbp_upd_o), .sbp_upd_stage_id_o(sbp_upd_stage_id_o),
    .sbp_upd_location_o(sbp_upd_location_o), .sbp_upd_length_o(sbp_upd_length_o),
    .sbp_upd_childs_stage_id_o(sbp_upd_childs_stage_id_o),
    .sbp_upd_childs_location_o(sbp_upd_childs_location_o),
    .sbp_upd_childs_lr_o(sbp_upd_childs_lr_o),
    .sbp_ip_addr_o(sbp_ip_addr_o), .sbp_ip_addr2_o(sbp_ip_addr2_o),
    .sbp_result_i(sbp_result_i), .sbp_result2_i(sbp_result2_i),
    .res_valid_o(res_valid_o), .res_tag_o(res_tag_o), .res_ip_addr_o(res_ip_addr_o),
    .res_result_o(res_result_o), .upd_busy_o(upd_busy_o)
  );

  typedef struct {
    logic [7:0]  tag;
    logic [31:0] addr;
    logic [23:0] res;
    int          exp_edge;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          n_checks = 0, n_fail = 0, n_popped = 0, ecnt = 0;
  logic [23:0] mtbl [16] = '{default: '0};
  logic [23:0] stbl [16] = '{default: '0};
  logic [23:0] p1 [L] = '{default: '0};
  logic [23:0] p2 [L] = '{default: '0};

  function automatic logic [23:0] upd_word(logic [1:0] lr, logic [5:0] stg, logic [10:0] loc,
                                           logic [5:0] len, logic [31:0] pfx);
    return {lr[0], stg, loc, len} ^ pfx[23:0];
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) ecnt <= ecnt + 1;

  // Pipeline model: port 1 results are scrambled so a wrong port selection is visible.
  always @(posedge clk) begin
    logic [23:0] r1, r2;
    r1 = mtbl[sbp_ip_addr_o[3:0]] ^ sbp_ip_addr_o[31:8];
    r2 = mtbl[sbp_ip_addr2_o[3:0]] ^ sbp_ip_addr2_o[31:8] ^ 24'h5A5A5A;
    for (int i = L - 1; i > 0; i--) begin
      p1[i] <= p1[i-1];
      p2[i] <= p2[i-1];
    end
    p1[0] <= r1;
    p2[0] <= r2;
    if (sbp_upd_o)
      mtbl[sbp_upd_location_o[3:0]] = upd_word(sbp_upd_childs_lr_o, sbp_upd_stage_id_o,
                                               sbp_upd_location_o, sbp_upd_length_o,
                                               sbp_ip_addr_o);
  end
  assign sbp_result_i  = p1[L-1];
  assign sbp_result2_i = p2[L-1];

  always @(negedge clk) begin
    if (res_valid_o === 1'b1) begin
      n_checks++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got tag %h addr %h, required no result", res_tag_o,
                 res_ip_addr_o);
      end else begin
        mon_e = sbq.pop_front();
        n_popped++;
        if (res_tag_o !== mon_e.tag || res_ip_addr_o !== mon_e.addr ||
            res_result_o !== mon_e.res || ecnt !== mon_e.exp_edge) begin
          n_fail++;
          $display("FAIL result: got tag %h addr %h res %h edge %0d, required tag %h addr %h res %h edge %0d",
                   res_tag_o, res_ip_addr_o, res_result_o, ecnt,
                   mon_e.tag, mon_e.addr, mon_e.res, mon_e.exp_edge);
        end
      end
    end
  end

  // Called at a negedge; drives one cycle and returns at the following negedge.
  task automatic drive(input bit lv, input logic [31:0] la, input logic [7:0] lt, input bit uv,
                       input bit ub, input logic [31:0] up, input logic [10:0] uloc,
                       input logic [5:0] ustg);
    exp_t e;
    bit   lacc, uacc;
    lkp_valid_i           = lv;
    lkp_ip_addr_i         = la;
    lkp_tag_i             = lt;
    upd_valid_i           = uv;
    upd_barrier_i         = ub;
    upd_prefix_i          = up;
    upd_location_i        = uloc;
    upd_stage_id_i        = ustg;
    upd_length_i          = ustg ^ 6'h15;
    upd_childs_stage_id_i = ustg + 6'd1;
    upd_childs_location_i = uloc ^ 11'h7FF;
    upd_childs_lr_i       = uloc[1:0];
    lacc = lv && (lkp_ready_o === 1'b1);
    uacc = uv && (upd_ready_o === 1'b1);
    if (lacc) begin
      e.tag      = lt;
      e.addr     = la;
      e.res      = stbl[la[3:0]] ^ la[31:8] ^ (uacc ? 24'h5A5A5A : 24'h0);
      e.exp_edge = ecnt + L + 2;
      sbq.push_back(e);
    end
    if (uacc)
      stbl[uloc[3:0]] = upd_word(uloc[1:0], ustg, uloc, ustg ^ 6'h15, up);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  task automatic wait_drain(input string name);
    int budget = 4 * L;
    while (sbq.size() != 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d results still outstanding, required 0", name, sbq.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({lkp_ready_o, upd_ready_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, required 00", {lkp_ready_o, upd_ready_o});
    end
    n_checks++;
    if ({res_valid_o, upd_busy_o, sbp_upd_o} !== 3'b000 || sbp_ip_addr_o !== 32'h0 ||
        sbp_ip_addr2_o !== 32'h0 || res_tag_o !== 8'h0 || res_result_o !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got res_valid %b busy %b upd %b addr %h addr2 %h, required all 0",
               res_valid_o, upd_busy_o, sbp_upd_o, sbp_ip_addr_o, sbp_ip_addr2_o);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({lkp_ready_o, upd_ready_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b, required 11", {lkp_ready_o, upd_ready_o});
    end
  endtask

  task automatic test_single();
    drive(1, 32'h0A000001, 8'h11, 0, 0, '0, '0, '0);
    n_checks++;
    if (sbp_ip_addr_o !== 32'h0A000001 || sbp_upd_o !== 1'b0 || sbp_ip_addr2_o !== 32'h0) begin
      n_fail++;
      $display("FAIL single_issue: got addr %h upd %b addr2 %h, required 0a000001 0 00000000",
               sbp_ip_addr_o, sbp_upd_o, sbp_ip_addr2_o);
    end
    idle(1);
    n_checks++;
    if (sbp_ip_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL idle_port0: got addr %h, required 00000000", sbp_ip_addr_o);
    end
    wait_drain("single");
  endtask

  task automatic test_simultaneous();
    n_checks++;
    if ({lkp_ready_o, upd_ready_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL simul_ready: got %b, required 11", {lkp_ready_o, upd_ready_o});
    end
    drive(1, 32'h0B000003, 8'h22, 1, 0, 32'hA1B2C3D4, 11'h403, 6'h07);
    n_checks++;
    if (sbp_upd_o !== 1'b1 || sbp_ip_addr_o !== 32'hA1B2C3D4 || sbp_ip_addr2_o !== 32'h0B000003) begin
      n_fail++;
      $display("FAIL simul_ports: got upd %b addr %h addr2 %h, required 1 a1b2c3d4 0b000003",
               sbp_upd_o, sbp_ip_addr_o, sbp_ip_addr2_o);
    end
    n_checks++;
    if (sbp_upd_stage_id_o !== 6'h07 || sbp_upd_location_o !== 11'h403 ||
        sbp_upd_length_o !== 6'h12 || sbp_upd_childs_stage_id_o !== 6'h08 ||
        sbp_upd_childs_location_o !== 11'h3FC || sbp_upd_childs_lr_o !== 2'b11) begin
      n_fail++;
      $display("FAIL simul_fields: got %h %h %h %h %h %b, required 07 403 12 08 3fc 11",
               sbp_upd_stage_id_o, sbp_upd_location_o, sbp_upd_length_o,
               sbp_upd_childs_stage_id_o, sbp_upd_childs_location_o, sbp_upd_childs_lr_o);
    end
    idle(1);
    n_checks++;
    if (sbp_upd_o !== 1'b0 || sbp_ip_addr2_o !== 32'h0) begin
      n_fail++;
      $display("FAIL simul_idle: got upd %b addr2 %h, required 0 00000000", sbp_upd_o, sbp_ip_addr2_o);
    end
    wait_drain("simul");
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    int start  = n_popped;
    for (int i = 0; i < 100; i++) begin
      if (lkp_ready_o !== 1'b1) stalls++;
      drive(1, $urandom, 8'(i), ($urandom_range(0, 2) == 0), 0, $urandom,
            11'($urandom_range(0, 2047)), 6'($urandom_range(0, 63)));
    end
    wait_drain("b2b");
    n_checks++;
    if (stalls != 0) begin
      n_fail++;
      $display("FAIL b2b_stall: got %0d stalled cycles, required 0", stalls);
    end
    n_checks++;
    if (n_popped - start != 100) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, required 100", n_popped - start);
    end
    idle(L + 2);
  endtask

  task automatic test_barrier();
    int low = 0;
    drive(0, '0, '0, 1, 1, 32'hCAFE1234, 11'h005, 6'h2A);
    while (lkp_ready_o !== 1'b1 && low < 200) begin
      low++;
      if (low == 2) begin
        n_checks++;
        if (upd_ready_o !== 1'b0) begin
          n_fail++;
          $display("FAIL barrier_upd_ready: got %b, required 0", upd_ready_o);
        end
      end
      drive(1, 32'h12345605, 8'h5B, 0, 0, '0, '0, '0);
    end
    n_checks++;
    if (low != L + 1) begin
      n_fail++;
      $display("FAIL barrier_stall: got %0d low cycles, required %0d", low, L + 1);
    end
    drive(1, 32'h12345605, 8'h5B, 0, 0, '0, '0, '0);
    wait_drain("barrier");
  endtask

  task automatic test_busy();
    int e0   = ecnt + 1;
    int errs = 0;
    for (int s = 0; s < L + 12; s++) begin
      if (s > 0) begin
        bit want = (ecnt >= e0) && (ecnt <= e0 + 4 + L);
        n_checks++;
        if (upd_busy_o !== want) begin
          n_fail++;
          errs++;
          if (errs < 5)
            $display("FAIL busy_edge%0d: got %b, required %b", ecnt - e0, upd_busy_o, want);
        end
      end
      drive(0, '0, '0, (s == 0 || s == 1 || s == 5), 0, 32'h0 + s, 11'(s + 8), 6'(s));
    end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    for (int i = 0; i < 10; i++)
      drive(1, 32'hC0A80000 + i, 8'(8'h80 + i), (i == 9), 0, 32'h0F0F0F0F, 11'h00E, 6'h11);
    lkp_valid_i = 1'b0;
    upd_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({lkp_ready_o, upd_ready_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset_ready: got %b, required 00", {lkp_ready_o, upd_ready_o});
    end
    @(negedge clk);
    sbq.delete();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({lkp_ready_o, upd_ready_o, upd_busy_o} !== 3'b110) begin
      n_fail++;
      $display("FAIL mid_reset_after: got ready/busy %b, required 110",
               {lkp_ready_o, upd_ready_o, upd_busy_o});
    end
    for (int i = 0; i < L + 6; i++) begin
      if (res_valid_o !== 1'b0) stray++;
      idle(1);
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL mid_reset_flush: got %0d stray results, required 0", stray);
    end
    drive(1, 32'h0A0000F3, 8'h77, 0, 0, '0, '0, '0);
    wait_drain("mid_reset");
  endtask

  initial begin
    rst = 1'b1;
    lkp_valid_i = 0; lkp_ip_addr_i = '0; lkp_tag_i = '0;
    upd_valid_i = 0; upd_barrier_i = 0; upd_prefix_i = '0; upd_length_i = '0;
    upd_stage_id_i = '0; upd_location_i = '0; upd_childs_stage_id_i = '0;
    upd_childs_location_i = '0; upd_childs_lr_i = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_barrier();
    idle(L + 2);
    test_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
